// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter merging N_INP valid/ready streams into one output stream.
// The data path is purely combinational; only the priority pointer and the grant lock are stored.
module stream_rr_arbiter #(
    parameter int DATA_W = 1,
    parameter int N_INP  = 0,
    parameter int IDX_W  = (N_INP > 1) ? $clog2(N_INP) : 1
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [N_INP-1:0][DATA_W-1:0]   inp_data_i,
    input  logic [N_INP-1:0]               inp_valid_i,
    output logic [N_INP-1:0]               inp_ready_o,
    output logic [DATA_W-1:0]              oup_data_o,
    output logic                           oup_valid_o,
    input  logic                           oup_ready_i,
    output logic [IDX_W-1:0]               oup_idx_o
);

    localparam int DW1 = IDX_W + 1;

    if (N_INP < 1) begin : g_bad_n_inp
        $fatal(1, "stream_rr_arbiter: N_INP must be >= 1");
    end

    // Handshake: a word moves in any cycle where oup_valid_o and oup_ready_i are both high;
    // once valid is offered the grant is frozen until that transfer happens.

    logic [IDX_W-1:0] rr_q, rr_d;
    logic             lock_q, lock_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic [IDX_W-1:0] grant;
    logic [IDX_W-1:0] scan_grant;
    logic [DW1-1:0]   scan_dist;
    logic [DW1-1:0]   best_dist;
    logic             xfer;

    // Scan distance from rr_q decides priority; the nearest valid input wins.
    always_comb begin
        scan_grant = rr_q;
        scan_dist  = '0;
        best_dist  = '1;
        for (int i = 0; i < N_INP; i++) begin
            if (DW1'(i) >= {1'b0, rr_q}) begin
                scan_dist = DW1'(i) - {1'b0, rr_q};
            end else begin
                scan_dist = DW1'(i) + DW1'(N_INP) - {1'b0, rr_q};
            end
            if (inp_valid_i[i] && (scan_dist < best_dist)) begin
                best_dist  = scan_dist;
                scan_grant = IDX_W'(i);
            end
        end
    end

    always_comb begin
        grant = lock_q ? idx_q : scan_grant;
    end

    always_comb begin
        oup_valid_o = 1'b0;
        oup_data_o  = '0;
        inp_ready_o = '0;
        oup_idx_o   = grant;
        for (int i = 0; i < N_INP; i++) begin
            if (grant == IDX_W'(i)) begin
                oup_valid_o    = inp_valid_i[i];
                oup_data_o     = inp_data_i[i];
                inp_ready_o[i] = oup_ready_i;
            end
        end
    end

    assign xfer = oup_valid_o & oup_ready_i;

    always_comb begin
        rr_d   = rr_q;
        lock_d = lock_q;
        idx_d  = idx_q;
        if (xfer) begin
            lock_d = 1'b0;
            if (grant == IDX_W'(N_INP - 1)) begin
                rr_d = '0;
            end else begin
                rr_d = grant + IDX_W'(1);
            end
        end else if (oup_valid_o) begin
            lock_d = 1'b1;
            idx_d  = grant;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_q   <= '0;
            lock_q <= 1'b0;
            idx_q  <= '0;
        end else begin
            rr_q   <= rr_d;
            lock_q <= lock_d;
            idx_q  <= idx_d;
        end
    end

    // A locked producer must keep its request up until it is accepted.
    a_locked_valid_held : assert property (@(posedge clk_i) disable iff (rst_i) lock_q |-> oup_valid_o);

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Bench for stream_rr_arbiter: N_INP=4, 3 and 1 instances against a spec-level model.
module tb_stream_rr_arbiter;

    logic clk;
    logic rst;

    logic [3:0]      v4;
    logic [3:0][7:0] d4;
    logic            r4;
    logic [3:0]      rdy4;
    logic [7:0]      od4;
    logic            ov4;
    logic [1:0]      oi4;

    logic [2:0]      v3;
    logic [2:0][7:0] d3;
    logic            r3;
    logic [2:0]      rdy3;
    logic [7:0]      od3;
    logic            ov3;
    logic [1:0]      oi3;

    logic [0:0]      v1;
    logic [0:0][7:0] d1;
    logic            r1;
    logic [0:0]      rdy1;
    logic [7:0]      od1;
    logic            ov1;
    logic [0:0]      oi1;

    // bench-side copies of what is driven, plus the reference model state
    logic [3:0] cur_v [3];
    logic       cur_r [3];
    logic [7:0] mdat  [3][4];
    logic [3:0] pend  [3];
    int         m_rr  [3];
    int         m_idx [3];
    bit         m_lock[3];
    int         nin   [3] = '{4, 3, 1};
    int         n_vec;
    int         n_err;

    stream_rr_arbiter #(.DATA_W(8), .N_INP(4)) u_dut4 (
        .clk_i(clk), .rst_i(rst), .inp_data_i(d4), .inp_valid_i(v4), .inp_ready_o(rdy4),
        .oup_data_o(od4), .oup_valid_o(ov4), .oup_ready_i(r4), .oup_idx_o(oi4)
    );
    stream_rr_arbiter #(.DATA_W(8), .N_INP(3)) u_dut3 (
        .clk_i(clk), .rst_i(rst), .inp_data_i(d3), .inp_valid_i(v3), .inp_ready_o(rdy3),
        .oup_data_o(od3), .oup_valid_o(ov3), .oup_ready_i(r3), .oup_idx_o(oi3)
    );
    stream_rr_arbiter #(.DATA_W(8), .N_INP(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .inp_data_i(d1), .inp_valid_i(v1), .inp_ready_o(rdy1),
        .oup_data_o(od1), .oup_valid_o(ov1), .oup_ready_i(r1), .oup_idx_o(oi1)
    );

    assign v4 = cur_v[0];
    assign r4 = cur_r[0];
    assign d4 = {mdat[0][3], mdat[0][2], mdat[0][1], mdat[0][0]};
    assign v3 = cur_v[1][2:0];
    assign r3 = cur_r[1];
    assign d3 = {mdat[1][2], mdat[1][1], mdat[1][0]};
    assign v1 = cur_v[2][0:0];
    assign r1 = cur_r[2];
    assign d1 = mdat[2][0];

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int model_grant(input int d);
        if (m_lock[d]) return m_idx[d];
        for (int k = 0; k < nin[d]; k++) begin
            int j;
            j = (m_rr[d] + k) % nin[d];
            if (cur_v[d][j]) return j;
        end
        return m_rr[d];
    endfunction

    task automatic reset_models();
        for (int d = 0; d < 3; d++) begin
            m_rr[d]   = 0;
            m_lock[d] = 1'b0;
            m_idx[d]  = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_dut(input int d);
        int          g;
        logic [31:0] o_idx, o_val, o_dat, o_rdy;
        g = model_grant(d);
        case (d)
            0:       begin o_idx = 32'(oi4); o_val = 32'(ov4); o_dat = 32'(od4); o_rdy = 32'(rdy4); end
            1:       begin o_idx = 32'(oi3); o_val = 32'(ov3); o_dat = 32'(od3); o_rdy = 32'(rdy3); end
            default: begin o_idx = 32'(oi1); o_val = 32'(ov1); o_dat = 32'(od1); o_rdy = 32'(rdy1); end
        endcase
        chk($sformatf("n%0d idx", nin[d]),   o_idx, 32'(g));
        chk($sformatf("n%0d valid", nin[d]), o_val, 32'(cur_v[d][g]));
        chk($sformatf("n%0d data", nin[d]),  o_dat, 32'(mdat[d][g]));
        chk($sformatf("n%0d ready", nin[d]), o_rdy, cur_r[d] ? (32'd1 << g) : 32'd0);
    endtask

    task automatic update_dut(input int d);
        int g;
        bit xfer;
        g    = model_grant(d);
        xfer = cur_v[d][g] && cur_r[d];
        if (xfer) begin
            m_rr[d]   = (g + 1) % nin[d];
            m_lock[d] = 1'b0;
        end else if (cur_v[d][g]) begin
            m_lock[d] = 1'b1;
            m_idx[d]  = g;
        end
        for (int i = 0; i < 4; i++) begin
            pend[d][i] = (i < nin[d]) && cur_v[d][i] && !(xfer && (i == g));
        end
    endtask

    // driver: one cycle of stimulus; pending requests stay valid with stable data
    task automatic apply(input logic [3:0] a4, input logic r_4, input logic [2:0] a3,
                         input logic r_3, input logic a1, input logic r_1);
        @(negedge clk);
        cur_v[0] = a4 | pend[0];
        cur_v[1] = {1'b0, a3} | pend[1];
        cur_v[2] = {3'b000, a1} | pend[2];
        cur_r[0] = r_4;
        cur_r[1] = r_3;
        cur_r[2] = r_1;
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 4; i++) begin
                if (!pend[d][i]) mdat[d][i] = 8'($urandom);
            end
        end
        #1;
        for (int d = 0; d < 3; d++) check_dut(d);
        @(posedge clk);
        for (int d = 0; d < 3; d++) update_dut(d);
    endtask

    task automatic step4(input logic [3:0] a4, input logic r_4);
        apply(a4, r_4, 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        for (int d = 0; d < 3; d++) begin
            cur_v[d] = '0;
            cur_r[d] = 1'b0;
            pend[d]  = '0;
            for (int i = 0; i < 4; i++) mdat[d][i] = 8'($urandom);
        end
        reset_models();
        #2;
        for (int d = 0; d < 3; d++) check_dut(d);
        cur_r[0] = 1'b1;
        cur_r[1] = 1'b1;
        cur_r[2] = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) check_dut(d);
        @(negedge clk);
        rst = 1'b0;

        // all requesting with ready high: N=4 rotates 0..3, N=3 rotates 0..2
        repeat (8) apply(4'hF, 1'b1, 3'b111, 1'b1, 1'($urandom), 1'($urandom));

        // backpressure holds grant 0, then 2 follows
        repeat (3) step4(4'b0101, 1'b0);
        step4(4'b0101, 1'b1);
        step4(4'b0100, 1'b1);

        // locked on 2 while 1 arrives; after release the scan from 3 reaches 1
        step4(4'b0100, 1'b0);
        step4(4'b0110, 1'b0);
        step4(4'b0110, 1'b1);
        step4(4'b0010, 1'b1);

        // rr=2, lock on 3, then asynchronous reset pulse between edges
        step4(4'b1000, 1'b0);
        step4(4'b1001, 1'b0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        reset_models();
        for (int d = 0; d < 3; d++) check_dut(d);
        #1 rst = 1'b0;
        @(posedge clk);
        for (int d = 0; d < 3; d++) update_dut(d);
        step4(4'b1001, 1'b1);
        step4(4'b1000, 1'b1);

        // randomized traffic on all three instances
        repeat (300) begin
            apply(4'($urandom), $urandom_range(0, 3) != 0,
                  3'($urandom), $urandom_range(0, 3) != 0,
                  1'($urandom), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
